hub75_bcm_scanner: RTL and testbench

- Parametrised next-generation HUB75 scan engine for the InfoBanner LED panels.
- Reads a dual-half-row framebuffer through one synchronous read port and shifts each column out over r0/g0/b0 and r1/g1/b1.
- Latches every row and drives OE with binary-coded modulation (BCM) across BPC bitplanes, giving true per-channel colour depth.
- Sits between the framebuffer memory's read port and the panel connector; replaces fixed-depth, fixed-size scanning.

---
 rtl/hub75_pkg.sv | 43 ++++
 rtl/hub75_bcm_timer.sv | 41 ++++
 rtl/hub75_bcm_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_hub75_bcm_scanner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM scan engine: FSM encoding,
// framebuffer channel layout and elaboration-time sizing helpers.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_e;

  // Channel slots inside fb_data, LSB first: {R1,G1,B1,R0,G0,B0}
  localparam int CH_B0 = 0;
  localparam int CH_G0 = 1;
  localparam int CH_R0 = 2;
  localparam int CH_B1 = 3;
  localparam int CH_G1 = 4;
  localparam int CH_R1 = 5;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int hub_clog2(input int value);
    int w;
    w = 1;
    while ((32'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int scan_rows(input int height);
    return height / 2;
  endfunction

  function automatic int num_cols(input int width, input int chained);
    return width * chained;
  endfunction

  function automatic int field_lsb(input int ch, input int bpc);
    return ch * bpc;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter that holds OE low for BASE_TIME<<plane clocks;
// done is high during the final counted clock.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BASE_TIME = 16,
  parameter int PLW       = 2,
  parameter int TW        = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [PLW-1:0] plane,
  output logic           done
);

  logic [TW-1:0] cnt_r;
  logic          active_r;
  logic [TW-1:0] dur_s;

  assign dur_s = TW'((BASE_TIME << plane) - 1);
  assign done  = active_r && (cnt_r == TW'(0));

  // Count the display window down from its loaded length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= TW'(0);
      active_r <= 1'b0;
    end else if (load) begin
      cnt_r    <= dur_s;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (cnt_r == TW'(0)) begin
        active_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - TW'(1);
      end
    end
  end

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine: shifts one bitplane of a scan row, latches it and
// shows it for BASE_TIME<<plane clocks, LSB plane first, row by row.
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 32,
  parameter int CHAINED   = 1,
  parameter int BPC       = 4,
  parameter int CLK_DIV   = 2,
  parameter int BASE_TIME = 16,
  parameter int ROW_W     = 4,
  parameter int AW        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [AW-1:0]    fb_addr,
  output logic             fb_rd_en,
  input  logic [6*BPC-1:0] fb_data,
  output logic             sclk,
  output logic             lat,
  output logic             oe,
  output logic [ROW_W-1:0] row_addr,
  output logic             r0,
  output logic             g0,
  output logic             b0,
  output logic             r1,
  output logic             g1,
  output logic             b1,
  output logic             busy,
  output logic             frame_done
);

  localparam int SR   = scan_rows(HEIGHT);
  localparam int COLS = num_cols(WIDTH, CHAINED);
  localparam int CW   = hub_clog2(COLS);
  localparam int PLW  = hub_clog2(BPC);
  localparam int PHW  = hub_clog2(2 * CLK_DIV + 2);
  localparam int TW   = hub_clog2((BASE_TIME << (BPC - 1)) + 1);

  // Column phases: 0 read, 1 capture, then CLK_DIV low and CLK_DIV high.
  localparam logic [PHW-1:0]   PH_CAP      = PHW'(1);
  localparam logic [PHW-1:0]   PH_HI       = PHW'(CLK_DIV + 2);
  localparam logic [PHW-1:0]   PH_LAST     = PHW'(2 * CLK_DIV + 1);
  localparam logic [PHW-1:0]   PH_LAT_LAST = PHW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    COL_LAST    = CW'(COLS - 1);
  localparam logic [PLW-1:0]   PL_LAST     = PLW'(BPC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(SR - 1);

  state_e           state_r, state_n;
  logic [PHW-1:0]   ph_r, ph_n;
  logic [CW-1:0]    col_r, col_n;
  logic [PLW-1:0]   plane_r, plane_n;
  logic [ROW_W-1:0] row_r, row_n;
  logic             fdone_s;
  logic             tmr_load_s;
  logic             tmr_done_s;
  logic             rd_s;
  logic [AW-1:0]    addr_s;
  logic [5:0]       plane_bits_s;

  hub75_bcm_timer #(
    .BASE_TIME (BASE_TIME),
    .PLW       (PLW),
    .TW        (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load_s),
    .plane (plane_r),
    .done  (tmr_done_s)
  );

  // Next state and scan counters.
  always_comb begin
    state_n    = state_r;
    ph_n       = ph_r;
    col_n      = col_r;
    plane_n    = plane_r;
    row_n      = row_r;
    fdone_s    = 1'b0;
    tmr_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_SHIFT;
          ph_n    = PHW'(0);
          col_n   = CW'(0);
          plane_n = PLW'(0);
          row_n   = ROW_W'(0);
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ph_r == PH_LAST) begin
          ph_n = PHW'(0);
          if (col_r == COL_LAST) begin
            col_n   = CW'(0);
            state_n = ST_BLANK;
          end else begin
            col_n = col_r + CW'(1);
          end
        end else begin
          ph_n = ph_r + PHW'(1);
        end
      end
      ST_BLANK: begin
        state_n = ST_LATCH;
        ph_n    = PHW'(0);
      end
      ST_LATCH: begin
        if (ph_r == PH_LAT_LAST) begin
          state_n    = ST_DISPLAY;
          ph_n       = PHW'(0);
          tmr_load_s = 1'b1;
        end else begin
          ph_n = ph_r + PHW'(1);
        end
      end
      ST_DISPLAY: begin
        if (tmr_done_s) begin
          if (plane_r == PL_LAST) begin
            plane_n = PLW'(0);
            if (row_r == ROW_LAST) begin
              row_n   = ROW_W'(0);
              fdone_s = 1'b1;
            end else begin
              row_n = row_r + ROW_W'(1);
            end
          end else begin
            plane_n = plane_r + PLW'(1);
          end
          state_n = enable ? ST_SHIFT : ST_IDLE;
        end else begin
          state_n = ST_DISPLAY;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Read strobe/address for the next cycle and the current plane's bit per channel.
  always_comb begin
    rd_s   = (state_n == ST_SHIFT) && (ph_n == PHW'(0));
    addr_s = AW'(int'(row_n) * COLS + int'(col_n));
    plane_bits_s = 6'd0;
    for (int c = 0; c < 6; c++) begin
      plane_bits_s[c] = 1'(fb_data[field_lsb(c, BPC) +: BPC] >> plane_r);
    end
  end

  // State, counters and every panel/memory output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ph_r       <= PHW'(0);
      col_r      <= CW'(0);
      plane_r    <= PLW'(0);
      row_r      <= ROW_W'(0);
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe         <= 1'b1;
      row_addr   <= ROW_W'(0);
      fb_rd_en   <= 1'b0;
      fb_addr    <= AW'(0);
      busy       <= 1'b0;
      frame_done <= 1'b0;
      r0         <= 1'b0;
      g0         <= 1'b0;
      b0         <= 1'b0;
      r1         <= 1'b0;
      g1         <= 1'b0;
      b1         <= 1'b0;
    end else begin
      state_r    <= state_n;
      ph_r       <= ph_n;
      col_r      <= col_n;
      plane_r    <= plane_n;
      row_r      <= row_n;
      sclk       <= (state_n == ST_SHIFT) && (ph_n >= PH_HI);
      lat        <= (state_n == ST_LATCH);
      oe         <= (state_n != ST_DISPLAY);
      busy       <= (state_n != ST_IDLE);
      frame_done <= fdone_s;
      fb_rd_en   <= rd_s;
      if (rd_s) begin
        fb_addr <= addr_s;
      end
      // Row select moves on the first LATCH clock, while the panel is dark.
      if (state_r == ST_BLANK) begin
        row_addr <= row_r;
      end
      if ((state_r == ST_SHIFT) && (ph_r == PH_CAP)) begin
        r0 <= plane_bits_s[CH_R0];
        g0 <= plane_bits_s[CH_G0];
        b0 <= plane_bits_s[CH_B0];
        r1 <= plane_bits_s[CH_R1];
        g1 <= plane_bits_s[CH_G1];
        b1 <= plane_bits_s[CH_B1];
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Self-checking bench for hub75_bcm_scanner on a 4x4 panel, 2 bitplanes:
// a monitor records panel events, a frame-level model predicts them.
module tb_hub75_bcm_scanner;

  localparam int W   = 4;
  localparam int SRN = 2;
  localparam int NPL = 2;
  localparam int BT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] fb_addr;
  logic        fb_rd_en;
  logic [11:0] fb_data;
  logic        sclk, lat, oe;
  logic [3:0]  row_addr;
  logic        r0, g0, b0, r1, g1, b1;
  logic        busy, frame_done;

  hub75_bcm_scanner #(
    .WIDTH(4), .HEIGHT(4), .CHAINED(1), .BPC(2), .CLK_DIV(1), .BASE_TIME(4),
    .ROW_W(4), .AW(12)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en),
    .fb_data(fb_data), .sclk(sclk), .lat(lat), .oe(oe), .row_addr(row_addr),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer: synchronous read, one clock of latency
  logic [11:0] mem [0:7];
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= mem[fb_addr[2:0]];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: panel events sampled on the falling edge
  logic [5:0] shift_q[$];
  int addr_q[$], oe_q[$], latlen_q[$], latrow_q[$], fd_q[$];
  int oe_run = 0, lat_run = 0, oe_runs_total = 0, fd_cycles = 0;
  int bad_row = 0, bad_latdisp = 0, bad_overlap = 0;
  logic sclk_p = 1'b0, oe_p = 1'b1, lat_p = 1'b0;
  logic [3:0] row_p = 4'd0;

  always @(negedge clk) begin
    if (rst) begin
      sclk_p <= 1'b0; oe_p <= 1'b1; lat_p <= 1'b0; row_p <= 4'd0;
      oe_run <= 0; lat_run <= 0;
    end else begin
      sclk_p <= sclk; oe_p <= oe; lat_p <= lat; row_p <= row_addr;
      if (sclk && !sclk_p) begin
        shift_q.push_back({r0, g0, b0, r1, g1, b1});
        if (!oe) bad_overlap <= bad_overlap + 1;
      end
      if (fb_rd_en) addr_q.push_back(int'(fb_addr));
      if (!oe) begin
        oe_run <= oe_run + 1;
        if (oe_p && !lat_p) bad_latdisp <= bad_latdisp + 1;
      end else if (oe_run != 0) begin
        oe_q.push_back(oe_run);
        oe_runs_total <= oe_runs_total + 1;
        oe_run <= 0;
      end
      if (lat) begin
        if (lat_run == 0) latrow_q.push_back(int'(row_addr));
        lat_run <= lat_run + 1;
      end else if (lat_run != 0) begin
        latlen_q.push_back(lat_run);
        lat_run <= 0;
      end
      if ((row_addr != row_p) && (!oe || !oe_p)) bad_row <= bad_row + 1;
      if (frame_done) begin
        fd_cycles <= fd_cycles + 1;
        fd_q.push_back(oe_runs_total + ((oe && oe_run != 0) ? 1 : 0));
      end
    end
  end

  // Reference: one bit of a 2-bit channel field (B0,G0,R0,B1,G1,R1 from LSB)
  function automatic logic fbit(input logic [11:0] px, input int ch, input int plane);
    return 1'((px >> (ch * 2 + plane)) & 12'd1);
  endfunction

  function automatic logic [5:0] exp_bits(input logic [11:0] px, input int plane);
    return {fbit(px, 2, plane), fbit(px, 1, plane), fbit(px, 0, plane),
            fbit(px, 5, plane), fbit(px, 4, plane), fbit(px, 3, plane)};
  endfunction

  initial begin
    logic [5:0] e_shift[$];
    int e_addr[$], e_oe[$], e_row[$];
    int k;

    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe", oe, 1); chk("rst_lat", lat, 0); chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0); chk("rst_rd_en", fb_rd_en, 0); chk("rst_addr", fb_addr, 0);
    chk("rst_row", row_addr, 0); chk("rst_fd", frame_done, 0);
    chk("rst_colour", {r0, g0, b0, r1, g1, b1}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_enable", busy, 0);

    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < 8; a++) begin
        if (f == 0) mem[a] = 12'h030;
        else if (f == 1) mem[a] = (a == 6) ? 12'h102 : 12'h000;
        else mem[a] = 12'($urandom);
      end
      shift_q.delete(); addr_q.delete(); oe_q.delete();
      latlen_q.delete(); latrow_q.delete(); fd_q.delete();

      enable = 1'b1;
      k = 0;
      while (!frame_done && k < 3000) begin @(negedge clk); k++; end
      chk("frame_done_seen", frame_done, 1);
      // Drop enable during plane 0 shift of the next frame
      enable = 1'b0;
      k = 0;
      while (busy && k < 200) begin @(negedge clk); k++; end
      chk("idle_busy", busy, 0);
      chk("idle_oe", oe, 1);
      repeat (3) @(negedge clk);

      if (f == 1 && shift_q.size() > 14) begin
        chk("px_g1_plane0", shift_q[10], 6'b000010);
        chk("px_b0_plane1", shift_q[14], 6'b001000);
      end

      // Full frame, then the partial row 0 / plane 0 finished after enable drop
      e_shift.delete(); e_addr.delete(); e_oe.delete(); e_row.delete();
      for (int r = 0; r < SRN; r++)
        for (int p = 0; p < NPL; p++) begin
          for (int c = 0; c < W; c++) begin
            e_shift.push_back(exp_bits(mem[r * W + c], p));
            e_addr.push_back(r * W + c);
          end
          e_oe.push_back(BT << p);
          e_row.push_back(r);
        end
      for (int c = 0; c < W; c++) begin
        e_shift.push_back(exp_bits(mem[c], 0));
        e_addr.push_back(c);
      end
      e_oe.push_back(BT);
      e_row.push_back(0);

      chk("shift_count", shift_q.size(), e_shift.size());
      for (int i = 0; i < e_shift.size() && i < shift_q.size(); i++) chk("shift_bits", shift_q[i], e_shift[i]);
      chk("addr_count", addr_q.size(), e_addr.size());
      for (int i = 0; i < e_addr.size() && i < addr_q.size(); i++) chk("fb_addr", addr_q[i], e_addr[i]);
      chk("oe_count", oe_q.size(), e_oe.size());
      for (int i = 0; i < e_oe.size() && i < oe_q.size(); i++) chk("oe_len", oe_q[i], e_oe[i]);
      chk("lat_count", latrow_q.size(), e_row.size());
      for (int i = 0; i < e_row.size() && i < latrow_q.size(); i++) chk("lat_row", latrow_q[i], e_row[i]);
      for (int i = 0; i < latlen_q.size(); i++) chk("lat_len", latlen_q[i], 1);
      chk("fd_count", fd_q.size(), 1);
      if (fd_q.size() > 0) chk("fd_position", fd_q[0], 5 * f + 4);
    end

    chk("fd_pulse_cycles", fd_cycles, 4);
    chk("row_change_while_lit", bad_row, 0);
    chk("display_without_latch", bad_latdisp, 0);
    chk("shift_during_display", bad_overlap, 0);

    // Asynchronous reset in the middle of DISPLAY
    enable = 1'b1;
    k = 0;
    while (oe && k < 500) begin @(negedge clk); k++; end
    chk("reach_display", oe, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_oe", oe, 1); chk("async_lat", lat, 0);
    chk("async_sclk", sclk, 0); chk("async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
